// File: rtl/dlfloat_host_link.sv
// Host-side link to the DLfloat16 MAC: serializes operand pairs onto the 16-bit
// link, captures the two-byte result after a fixed latency and queues it in a 2-deep FIFO.
module dlfloat_host_link #(
  parameter int unsigned RESP_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] op_a,
  input  logic [15:0] op_b,
  input  logic        op_valid,
  output logic        op_ready,
  output logic [15:0] link_data,
  input  logic [7:0]  link_byte,
  output logic [15:0] res_data,
  output logic        res_valid,
  input  logic        res_ready,
  output logic        busy,
  output logic        nan_seen
);

  typedef enum logic [2:0] {
    IDLE, SEND_A, SEND_B, WAIT, CAP_HI, CAP_LO
  } state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(RESP_LAT - 1);

  state_t      state;
  logic [15:0] b_q;
  logic [3:0]  cnt;
  logic [7:0]  hi;

  logic [15:0] mem [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic [1:0]  count;

  logic        push;
  logic        pop;
  logic        rd_next;
  logic [15:0] push_data;

  assign op_ready  = (state == IDLE) && (count < 2'd2);
  assign busy      = (state != IDLE);
  assign res_valid = (count != 2'd0);
  assign push      = (state == CAP_LO);
  assign pop       = res_valid && res_ready;
  assign push_data = {hi, link_byte};
  assign rd_next   = pop ? ~rd_ptr : rd_ptr;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      b_q       <= 16'h0000;
      cnt       <= 4'd0;
      hi        <= 8'h00;
      link_data <= 16'h0000;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid && op_ready) begin
            b_q       <= op_b;
            link_data <= op_a;
            state     <= SEND_A;
          end
        end
        SEND_A: begin
          link_data <= b_q;
          state     <= SEND_B;
        end
        SEND_B: begin
          link_data <= 16'h0000;
          cnt       <= WAIT_LOAD;
          state     <= (RESP_LAT == 1) ? CAP_HI : WAIT;
        end
        WAIT: begin
          // leaving on the count-to-zero step keeps the hi sample at k+2+RESP_LAT
          cnt <= cnt - 4'd1;
          if (cnt <= 4'd1) state <= CAP_HI;
        end
        CAP_HI: begin
          hi    <= link_byte;
          state <= CAP_LO;
        end
        CAP_LO: begin
          state <= IDLE;
        end
        default: begin
          link_data <= 16'h0000;
          state     <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem[0]   <= 16'h0000;
      mem[1]   <= 16'h0000;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      res_data <= 16'h0000;
      nan_seen <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
        if (push_data == 16'hFFFF) nan_seen <= 1'b1;
      end
      rd_ptr <= rd_next;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
      // registered head: bypass the word being written when it lands in the next head slot
      if (push && (wr_ptr == rd_next)) res_data <= push_data;
      else                             res_data <= mem[rd_next];
    end
  end

endmodule

// File: tb/tb_dlfloat_host_link.sv
// Self-checking bench for dlfloat_host_link: drives operand pairs, plays the MAC
// return bytes at the expected cycles and scoreboards the result FIFO.
module tb_dlfloat_host_link;
  localparam int unsigned L = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] op_a = 16'h0, op_b = 16'h0;
  logic        op_valid = 1'b0;
  logic        op_ready;
  logic [15:0] link_data;
  logic [7:0]  link_byte = 8'hA5;
  logic [15:0] res_data;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic        busy;
  logic        nan_seen;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [$];

  dlfloat_host_link #(.RESP_LAT(L)) dut (
    .clk(clk), .rst_n(rst_n), .op_a(op_a), .op_b(op_b), .op_valid(op_valid),
    .op_ready(op_ready), .link_data(link_data), .link_byte(link_byte),
    .res_data(res_data), .res_valid(res_valid), .res_ready(res_ready),
    .busy(busy), .nan_seen(nan_seen)
  );

  always #5 clk = ~clk;

  // Offer a pair, wait (bounded) for acceptance; returns 1 when accepted.
  task automatic offer(input logic [15:0] a, input logic [15:0] b, output bit ok);
    ok = 1'b0;
    @(negedge clk);
    op_a = a; op_b = b; op_valid = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (op_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL accept_timeout: op_ready stayed %b, required 1", op_ready);
    end
  endtask

  // One full transaction; optional pop on the same edge as the push.
  task automatic do_txn(input logic [15:0] a, input logic [15:0] b,
                        input logic [7:0] rh, input logic [7:0] rl, input bit pop_same);
    bit ok;
    offer(a, b, ok);
    if (!ok) return;
    for (int n = 1; n <= int'(L) + 4; n++) begin
      @(negedge clk);
      if (n == 1) begin
        op_valid = 1'b0;
        checks++;
        if (link_data !== a) begin errors++; $display("FAIL link_a: got %h, required %h", link_data, a); end
        checks++;
        if (busy !== 1'b1 || op_ready !== 1'b0) begin
          errors++; $display("FAIL busy_ready: busy=%b op_ready=%b, required 1/0", busy, op_ready);
        end
      end
      if (n == 2) begin
        checks++;
        if (link_data !== b) begin errors++; $display("FAIL link_b: got %h, required %h", link_data, b); end
      end
      if (n == 3) begin
        checks++;
        if (link_data !== 16'h0) begin errors++; $display("FAIL link_idle: got %h, required 0000", link_data); end
      end
      if (n == int'(L) + 2) link_byte = rh;
      if (n == int'(L) + 3) begin
        link_byte = rl;
        if (pop_same) begin
          checks++;
          if (res_valid !== 1'b1 || res_data !== exp_q[0]) begin
            errors++; $display("FAIL same_edge_head: valid=%b data=%h, required 1/%h", res_valid, res_data, exp_q[0]);
          end
          void'(exp_q.pop_front());
          res_ready = 1'b1;
        end
      end
      if (n == int'(L) + 4) begin
        link_byte = 8'hA5;
        res_ready = 1'b0;
        exp_q.push_back({rh, rl});
      end
    end
  endtask

  task automatic pop_check(input string name);
    logic [15:0] e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++; $display("FAIL %s: scoreboard empty, res_valid=%b", name, res_valid);
      return;
    end
    e = exp_q.pop_front();
    if (res_valid !== 1'b1 || res_data !== e) begin
      errors++; $display("FAIL %s: valid=%b data=%h, required 1/%h", name, res_valid, res_data, e);
    end
    res_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (link_data !== 16'h0 || res_valid !== 1'b0 || busy !== 1'b0 || nan_seen !== 1'b0 || res_data !== 16'h0) begin
      errors++;
      $display("FAIL %s: link=%h valid=%b busy=%b nan=%b data=%h, required 0000/0/0/0/0000",
               name, link_data, res_valid, busy, nan_seen, res_data);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %b, required 1", op_ready); end
  endtask

  task automatic test_basic;
    do_txn(16'h3E00, 16'h4000, 8'h40, 8'h00, 1'b0);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'h4000) begin
      errors++; $display("FAIL basic_result: valid=%b data=%h, required 1/4000", res_valid, res_data);
    end
    pop_check("basic_pop");
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL basic_empty: res_valid=%b, required 0", res_valid); end
  endtask

  task automatic test_backpressure;
    do_txn(16'h1111, 16'h2222, 8'h3E, 8'h00, 1'b0);
    do_txn(16'h3333, 16'h4444, 8'h40, 8'h00, 1'b0);
    checks++;
    if (op_ready !== 1'b0 || res_valid !== 1'b1) begin
      errors++; $display("FAIL full_ready: op_ready=%b res_valid=%b, required 0/1", op_ready, res_valid);
    end
    pop_check("full_pop_head");
    checks++;
    if (op_ready !== 1'b1 || res_data !== 16'h4000) begin
      errors++; $display("FAIL after_pop: op_ready=%b data=%h, required 1/4000", op_ready, res_data);
    end
    pop_check("full_pop_second");
  endtask

  task automatic test_simultaneous;
    do_txn(16'h0001, 16'h0002, 8'h3E, 8'h00, 1'b0);
    do_txn(16'h0003, 16'h0004, 8'hC0, 8'h00, 1'b1);
    checks++;
    if (res_valid !== 1'b1 || res_data !== 16'hC000) begin
      errors++; $display("FAIL simul_head: valid=%b data=%h, required 1/C000", res_valid, res_data);
    end
    pop_check("simul_pop");
    checks++;
    if (res_valid !== 1'b0) begin errors++; $display("FAIL simul_count: res_valid=%b, required 0", res_valid); end
  endtask

  task automatic test_nan;
    checks++;
    if (nan_seen !== 1'b0) begin errors++; $display("FAIL nan_initial: got %b, required 0", nan_seen); end
    do_txn(16'h7E00, 16'h7E00, 8'hFF, 8'hFF, 1'b0);
    checks++;
    if (nan_seen !== 1'b1) begin errors++; $display("FAIL nan_set: got %b, required 1", nan_seen); end
    pop_check("nan_pop");
    do_txn(16'h3E00, 16'h4000, 8'h40, 8'h00, 1'b0);
    checks++;
    if (nan_seen !== 1'b1) begin errors++; $display("FAIL nan_sticky: got %b, required 1", nan_seen); end
    // leave 4000 queued so the next reset has something to clear
  endtask

  task automatic test_reset_mid;
    bit ok;
    offer(16'h1234, 16'h5678, ok);
    @(negedge clk);
    op_valid = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset_mid");
    exp_q.delete();
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (op_ready !== 1'b1) begin errors++; $display("FAIL reset_mid_ready: got %b, required 1", op_ready); end
  endtask

  task automatic test_reset_wait;
    bit ok;
    offer(16'hAAAA, 16'h5555, ok);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      op_valid = 1'b0;
    end
    rst_n = 1'b0;
    link_byte = 8'h77;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    link_byte = 8'hA5;
    repeat (int'(L) + 4) @(negedge clk);
    check_reset_outputs("reset_wait");
    do_txn(16'h3E00, 16'h3E00, 8'h3E, 8'h00, 1'b0);
    pop_check("after_reset_wait");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_simultaneous();
    test_nan();
    test_reset_mid();
    test_reset_wait();
    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/dlfloat_host_link.md
Name: dlfloat_host_link

Overview:
- Host-side counterpart of the DLfloat16 MAC pin interface.
- Takes operand pairs (a, b) on a valid/ready port and serializes them onto the 16-bit link as two consecutive words (a, then b).
- Waits a fixed response latency, then captures the two result bytes (high, then low) from the 8-bit return link.
- Reassembles the 16-bit DLfloat16 result and queues it in a 2-entry result FIFO.
- Used in the FPGA/bench harness and the planned host controller that drives the MAC.

Parameters:
- RESP_LAT, 4, cycles from the cycle b is driven to the edge that samples the high result byte; legal range 1..15.

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  synchronous, active-low reset.
- op_a  in  16  operand a (DLfloat16: sign[15], exp[14:9] bias 31, mant[8:0]).
- op_b  in  16  operand b.
- op_valid  in  1  operand pair valid.
- op_ready  out  1  block can accept an operand pair.
- link_data  out  16  word driven toward the MAC ({uio_in, ui_in}).
- link_byte  in  8  byte returned from the MAC (uo_out).
- res_data  out  16  head of the result FIFO.
- res_valid  out  1  result FIFO not empty.
- res_ready  in  1  consumer pops the head.
- busy  out  1  FSM is not in IDLE.
- nan_seen  out  1  sticky flag; set when any captured result equals 16'hFFFF.

Behaviour:
- Reset:
  - Synchronous, active-low.
  - Asserted at any time, including mid-transaction, it forces state IDLE, clears the FIFO (count=0, pointers=0), link_data=0, res_data=0, res_valid=0, busy=0 and nan_seen=0.
  - op_ready=1 in the first cycle after rst_n returns high.
- FSM states: IDLE, SEND_A, SEND_B, WAIT, CAP_HI, CAP_LO.
  - IDLE: op_ready=1 iff FIFO count<2. On op_valid&&op_ready at edge k, latch op_a/op_b and go to SEND_A.
  - SEND_A: link_data=a during cycle k+1. Go to SEND_B.
  - SEND_B: link_data=b during cycle k+2. Load wait counter with RESP_LAT-1. Go to WAIT, or to CAP_HI directly when RESP_LAT=1.
  - WAIT: decrement the counter each cycle. Go to CAP_HI when the counter reaches 0.
  - CAP_HI: sample link_byte into hi at edge k+2+RESP_LAT.
  - CAP_LO: sample link_byte into lo at edge k+3+RESP_LAT. At that edge, push {hi, lo} into the FIFO and return to IDLE.
- link_data=0 in every state other than SEND_A and SEND_B.
- op_ready=0 outside IDLE. Only one transaction is in flight at a time.
- Next accept: earliest at edge k+4+RESP_LAT. Throughput is 1 pair per RESP_LAT+4 cycles.
- FIFO:
  - 2 entries, first-in first-out; res_data is a registered view of the head.
  - A push never occurs when count=2, because op_ready gating guarantees space.
  - A pop occurs on res_valid&&res_ready.
  - Push and pop on the same edge: count unchanged, order preserved.
  - Pop when empty is ignored.
  - With count=2 and a pop at edge j, op_ready=1 during cycle j+1.
- res_valid rises in the cycle after the push edge. With an empty FIFO, res_data is valid in that same cycle.
- nan_seen is set on the push of 16'hFFFF and stays set until reset. No other error handling; the payload is passed through unchanged.
- busy = (state != IDLE).
- op_valid deasserted, or op_a/op_b changing while not accepted: no effect.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles mid-stream -> link_data=0, res_valid=0, busy=0, nan_seen=0; op_ready=1 in the first cycle after release.
- Basic (RESP_LAT=4): accept a=16'h3E00 (1.0), b=16'h4000 (2.0) at edge k -> link_data=3E00 in cycle k+1, 4000 in cycle k+2, 0 afterwards. Bench drives link_byte=8'h40 before edge k+6 and 8'h00 before edge k+7 -> res_valid=1 with res_data=16'h4000 in cycle k+8.
- Backpressure: res_ready=0, op_valid held with results 16'h3E00 then 16'h4000 -> two transactions complete, FIFO count=2, op_ready=0. Pop once -> res_data=16'h3E00 leaves, op_ready=1 next cycle, head becomes 16'h4000.
- Simultaneous push/pop: count=1 with head 16'h3E00; pop on the same edge as a push of 16'hC000 -> count stays 1, res_data=16'hC000 next cycle.
- NaN: return bytes 8'hFF, 8'hFF -> res_data=16'hFFFF and nan_seen=1. A following normal result 16'h4000 leaves nan_seen=1.
- Reset in WAIT: assert rst_n=0 two cycles after b is driven -> no result is pushed, link_data=0, busy=0 after reset. A new op pair then completes normally.
